// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: pipeline-latch controller states and PC-source encodings.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    DWAIT  = 3'd1,
    SQUASH = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } pctrl_state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;

endpackage

// File: rtl/pipeline_latch_ctrl_if.sv
// Bundle of pipeline_latch_ctrl signals; modport plc for the block, plctb for a bench.
// Statistic counters appear only when PIPE_STATS_EN is defined.
interface pipeline_latch_ctrl_if;
  logic       CLK;
  logic       RST;
  logic       IFdopause;
  logic       IDdopause;
  logic       ihit;
  logic       dhit;
  logic       dmemREN;
  logic       dmemWEN;
  logic [1:0] PCSrc;
  logic       halt;
  logic       pc_en;
  logic       IFID_en;
  logic       IFID_flush;
  logic       IDEX_en;
  logic       IDEX_flush;
  logic       EXMEM_en;
  logic       MEMWB_en;
  logic       halted;
`ifdef PIPE_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] squash_events;
  logic [31:0] dwait_cycles;
`endif

  modport plc (
    input  CLK, RST, IFdopause, IDdopause, ihit, dhit, dmemREN, dmemWEN, PCSrc, halt,
    output pc_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_en, halted
`ifdef PIPE_STATS_EN
    , output stall_cycles, squash_events, dwait_cycles
`endif
  );

  modport plctb (
    output CLK, RST, IFdopause, IDdopause, ihit, dhit, dmemREN, dmemWEN, PCSrc, halt,
    input  pc_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_en, halted
`ifdef PIPE_STATS_EN
    , input stall_cycles, squash_events, dwait_cycles
`endif
  );

endinterface

// File: rtl/pipeline_latch_ctrl.sv
// Per-latch enable/flush control with memory-wait, branch-squash and halt-drain sequencing.
// Optional statistic counters are built when PIPE_STATS_EN is defined.
module pipeline_latch_ctrl
  import cpu_types_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2,
  parameter int HALT_DRAIN    = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IFdopause,
  input  logic       IDdopause,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       dmemREN,
  input  logic       dmemWEN,
  input  logic [1:0] PCSrc,
  input  logic       halt,
  output logic       pc_en,
  output logic       IFID_en,
  output logic       IFID_flush,
  output logic       IDEX_en,
  output logic       IDEX_flush,
  output logic       EXMEM_en,
  output logic       MEMWB_en,
  output logic       halted
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] squash_events,
  output logic [31:0] dwait_cycles
`endif
);

  pctrl_state_t state, next_state;
  logic [2:0]   squash_cnt, squash_next;
  logic [1:0]   drain_cnt, drain_next;
  logic         dmem_pend;
  logic         squash_mode;
  logic         branch_take;

  assign dmem_pend = (dmemREN | dmemWEN) & ~dhit;

  // Next-state, counter and Mealy latch-control decode.
  always_comb begin
    pc_en       = 1'b0;
    IFID_en     = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_en     = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_en    = 1'b0;
    MEMWB_en    = 1'b0;
    halted      = 1'b0;
    next_state  = state;
    squash_next = squash_cnt;
    drain_next  = drain_cnt;
    branch_take = 1'b0;
    // A memory wait entered mid-squash resumes squashing once dhit arrives.
    squash_mode = (state == SQUASH) || ((state == DWAIT) && (squash_cnt != 3'd0));
    if (RST) begin
      next_state  = RUN;
      squash_next = 3'd0;
      drain_next  = 2'd0;
    end else begin
      case (state)
        HALTED: begin
          halted = 1'b1;
        end
        DRAIN: begin
          IFID_en    = 1'b1;
          IFID_flush = 1'b1;
          IDEX_en    = 1'b1;
          IDEX_flush = 1'b1;
          EXMEM_en   = 1'b1;
          MEMWB_en   = 1'b1;
          drain_next = (drain_cnt == 2'd0) ? 2'd0 : drain_cnt - 2'd1;
          next_state = (drain_cnt <= 2'd1) ? HALTED : DRAIN;
        end
        RUN, SQUASH, DWAIT: begin
          if (dmem_pend) begin
            next_state = DWAIT;
          end else if (halt) begin
            IFID_en     = 1'b1;
            IFID_flush  = 1'b1;
            IDEX_en     = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_en    = 1'b1;
            MEMWB_en    = 1'b1;
            squash_next = 3'd0;
            if (HALT_DRAIN == 0) begin
              next_state = HALTED;
            end else begin
              drain_next = 2'(HALT_DRAIN);
              next_state = DRAIN;
            end
          end else if (PCSrc != PCSRC_SEQ) begin
            pc_en       = 1'b1;
            IFID_en     = 1'b1;
            IFID_flush  = 1'b1;
            IDEX_en     = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_en    = 1'b1;
            MEMWB_en    = 1'b1;
            branch_take = 1'b1;
            squash_next = 3'(SQUASH_CYCLES - 1);
            next_state  = (SQUASH_CYCLES > 1) ? SQUASH : RUN;
          end else begin
            if (IDdopause) begin
              IDEX_en    = 1'b1;
              IDEX_flush = 1'b1;
              EXMEM_en   = 1'b1;
              MEMWB_en   = 1'b1;
            end else if (IFdopause || !ihit) begin
              IFID_en    = 1'b1;
              IFID_flush = 1'b1;
              IDEX_en    = 1'b1;
              EXMEM_en   = 1'b1;
              MEMWB_en   = 1'b1;
            end else begin
              pc_en    = 1'b1;
              IFID_en  = 1'b1;
              IDEX_en  = 1'b1;
              EXMEM_en = 1'b1;
              MEMWB_en = 1'b1;
            end
            // Squash bubbles are only consumed on cycles IF/ID actually loads.
            if (squash_mode) begin
              if (IFID_en) begin
                IFID_flush  = 1'b1;
                squash_next = (squash_cnt == 3'd0) ? 3'd0 : squash_cnt - 3'd1;
                next_state  = (squash_cnt <= 3'd1) ? RUN : SQUASH;
              end else begin
                next_state = SQUASH;
              end
            end else begin
              next_state = RUN;
            end
          end
        end
        default: begin
          next_state = RUN;
        end
      endcase
    end
  end

  // State and sequencing counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RUN;
      squash_cnt <= 3'd0;
      drain_cnt  <= 2'd0;
    end else begin
      state      <= next_state;
      squash_cnt <= squash_next;
      drain_cnt  <= drain_next;
    end
  end

`ifdef PIPE_STATS_EN
  // Free-running statistics, frozen once the pipe has halted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles  <= 32'd0;
      squash_events <= 32'd0;
      dwait_cycles  <= 32'd0;
    end else if (!halted) begin
      stall_cycles  <= stall_cycles + {31'd0, ~pc_en};
      squash_events <= squash_events + {31'd0, branch_take};
      dwait_cycles  <= dwait_cycles + {31'd0, (state == DWAIT)};
    end else begin
      stall_cycles  <= stall_cycles;
      squash_events <= squash_events;
      dwait_cycles  <= dwait_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_latch_ctrl.sv
// Scoreboard bench for pipeline_latch_ctrl: driver queues hand-computed expectations, monitor checks each cycle.
module tb_pipeline_latch_ctrl;

  // Output vector order: pc_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_en, halted
  localparam logic [7:0] O_ZERO = 8'b0000_0000;
  localparam logic [7:0] O_NORM = 8'b1101_0110;
  localparam logic [7:0] O_BR   = 8'b1111_1110;
  localparam logic [7:0] O_SQ   = 8'b1111_0110;
  localparam logic [7:0] O_LU   = 8'b0001_1110;
  localparam logic [7:0] O_IFS  = 8'b0111_0110;
  localparam logic [7:0] O_HLT  = 8'b0111_1110;
  localparam logic [7:0] O_HLTD = 8'b0000_0001;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic stim_done = 1'b0;

  pipeline_latch_ctrl_if bus ();

  pipeline_latch_ctrl #(.SQUASH_CYCLES(2), .HALT_DRAIN(2)) dut (
    .CLK        (bus.CLK),
    .RST        (bus.RST),
    .IFdopause  (bus.IFdopause),
    .IDdopause  (bus.IDdopause),
    .ihit       (bus.ihit),
    .dhit       (bus.dhit),
    .dmemREN    (bus.dmemREN),
    .dmemWEN    (bus.dmemWEN),
    .PCSrc      (bus.PCSrc),
    .halt       (bus.halt),
    .pc_en      (bus.pc_en),
    .IFID_en    (bus.IFID_en),
    .IFID_flush (bus.IFID_flush),
    .IDEX_en    (bus.IDEX_en),
    .IDEX_flush (bus.IDEX_flush),
    .EXMEM_en   (bus.EXMEM_en),
    .MEMWB_en   (bus.MEMWB_en),
    .halted     (bus.halted)
`ifdef PIPE_STATS_EN
    ,
    .stall_cycles  (bus.stall_cycles),
    .squash_events (bus.squash_events),
    .dwait_cycles  (bus.dwait_cycles)
`endif
  );

  initial begin
    bus.CLK = 1'b0;
    forever #5 bus.CLK = ~bus.CLK;
  end

  // Drive one cycle of inputs just after the rising edge and queue its expected outputs.
  task automatic step(input logic rst, input logic ifp, input logic idp, input logic ih,
                      input logic dh, input logic ren, input logic wen, input logic [1:0] pcs,
                      input logic hlt, input logic [7:0] exp, input string name);
    exp_t e;
    @(posedge bus.CLK);
    #1;
    bus.RST       = rst;
    bus.IFdopause = ifp;
    bus.IDdopause = idp;
    bus.ihit      = ih;
    bus.dhit      = dh;
    bus.dmemREN   = ren;
    bus.dmemWEN   = wen;
    bus.PCSrc     = pcs;
    bus.halt      = hlt;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: every falling edge the DUT presents one cycle of outputs.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge bus.CLK);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.pc_en, bus.IFID_en, bus.IFID_flush, bus.IDEX_en, bus.IDEX_flush,
               bus.EXMEM_en, bus.MEMWB_en, bus.halted};
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    bus.RST = 1'b1; bus.IFdopause = 1'b0; bus.IDdopause = 1'b0; bus.ihit = 1'b1;
    bus.dhit = 1'b0; bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.PCSrc = 2'b00; bus.halt = 1'b0;

    //   rst   ifp   idp   ihit  dhit  ren   wen   pcs    halt
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_ZERO, "reset0");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_ZERO, "reset1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_NORM, "run0");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_NORM, "run1");
    // Load miss: three wait cycles, then release on dhit.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, O_ZERO, "dwait_load");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, O_NORM, "dhit_release");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_NORM, "after_dwait");
    // Taken branch: flush both, then one squash bubble.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, O_BR,   "branch");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_SQ,   "squash1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_NORM, "squash_done");
    // Branch beats load-use; load-use in SQUASH holds the bubble count.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, O_BR,   "branch_over_lu");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_LU,   "lu_in_squash");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_SQ,   "squash_after_lu");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_NORM, "run_after_sq");
    // Load-use, icache miss, IF hold.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_LU,   "loaduse");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_IFS,  "imiss");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_IFS,  "ifpause");
    // Store miss freezes; dhit cycle re-evaluates with an icache miss present.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, O_ZERO, "store_pend");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, O_IFS,  "store_hit_imiss");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_NORM, "run2");
    // Branch arriving on the dhit cycle of a wait.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, O_ZERO, "pend_hides_branch");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, O_BR,   "dhit_branch");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_SQ,   "dhit_branch_sq");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_NORM, "run3");
    // Reset in SQUASH returns to RUN with no leftover bubble.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, O_BR,   "branch_b");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_ZERO, "rst_in_squash");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_NORM, "run_after_rst_sq");
    // Reset in DRAIN.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, O_HLT,  "halt_a");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_ZERO, "rst_in_drain");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_NORM, "run_after_rst_dr");
    // Halt: halt cycle + two drain cycles, then frozen.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, O_HLT,  "halt");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_HLT,  "drain1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, O_HLT,  "drain2_ignore_pend");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_HLTD, "halted0");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, O_HLTD, "halted_dmem");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, O_HLTD, "halted_branch");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_ZERO, "rst_in_halted");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, O_NORM, "run_after_halt");
    stim_done = 1'b1;
  end

  // Wait, bounded, for the monitor to drain the scoreboard, then summarise.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge bus.CLK);
    @(posedge bus.CLK);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
